// File: rtl/dspba_fifo_rd_adapter_pkg.sv
// dspba_fifo_rd_pkg
// Shared constants and helpers for the FIFO read-side adapter.
//   MAX_RD_LATENCY : largest supported source FIFO read latency.
//   cnt_w(n)       : bits needed to hold a count in 0..n.
package dspba_fifo_rd_pkg;

  localparam int MAX_RD_LATENCY = 4;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dspba_fifo_rd_adapter_if.sv
// dspba_fifo_rd_adapter_if
// Bundles the source-FIFO read port and the downstream valid/ready stream.
//   fifo_empty, fifo_rdreq, fifo_q : non-showahead source FIFO read side
//   out_valid, out_ready, out_data  : showahead output stream
// Modports:
//   slave  : the adapter (drives fifo_rdreq and the output stream)
//   master : the environment (drives the FIFO side and out_ready)
interface dspba_fifo_rd_adapter_if #(
  parameter int width = 8
);
  logic             fifo_empty;
  logic             fifo_rdreq;
  logic [width-1:0] fifo_q;
  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] out_data;

  modport slave (
    input  fifo_empty, fifo_q, out_ready,
    output fifo_rdreq, out_valid, out_data
  );

  modport master (
    output fifo_empty, fifo_q, out_ready,
    input  fifo_rdreq, out_valid, out_data
  );
endinterface

// File: rtl/dspba_fifo_rd_buffer.sv
// dspba_fifo_rd_buffer
// depth-entry register buffer with showahead head output. Absorbs words
// returning from the source FIFO so downstream backpressure never drops data.
//   clk, reset : clock, asynchronous active-low reset
//   push       : write push_data at the write pointer
//   push_data  : word returning from the source FIFO
//   pop        : consume the head word
//   count      : number of words held (0..depth)
//   head_data  : word at the read pointer (stale when count == 0)
module dspba_fifo_rd_buffer
  import dspba_fifo_rd_pkg::*;
#(
  parameter int width = 8,
  parameter int depth = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [width-1:0]          push_data,
  input  logic                      pop,
  output logic [cnt_w(depth)-1:0]   count,
  output logic [width-1:0]          head_data
);

  localparam int PTR_W = (depth > 1) ? $clog2(depth) : 1;
  localparam int CNT_W = cnt_w(depth);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [width-1:0] entry_q [depth];

  // depth is rd_latency + 1 and need not be a power of two, so the pointers
  // wrap on an explicit compare rather than on natural overflow.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(depth - 1)) ? '0 : p + 1'b1;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < depth; gi++) begin : g_entry
      logic [width-1:0] entry_reg;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          entry_reg <= '0;
        else if (push && (wr_ptr_reg == PTR_W'(gi)))
          entry_reg <= push_data;
      end
      assign entry_q[gi] = entry_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      // push together with pop leaves the occupancy unchanged, even when full
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign count     = count_reg;
  assign head_data = entry_q[rd_ptr_reg];

  // The credit logic upstream must make overflow impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && (count_reg == CNT_W'(depth))));

endmodule

// File: rtl/dspba_fifo_rd_adapter.sv
// dspba_fifo_rd_adapter
// Drains a non-showahead FIFO with fixed read latency and presents its
// contents as a valid/ready stream.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : dspba_fifo_rd_adapter_if.slave
//                fifo_empty/fifo_q in, fifo_rdreq out (combinational),
//                out_valid/out_data out (showahead), out_ready in
// Parameters: width (data bits), rd_latency (1..MAX_RD_LATENCY).
module dspba_fifo_rd_adapter
  import dspba_fifo_rd_pkg::*;
#(
  parameter int width      = 8,
  parameter int rd_latency = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  dspba_fifo_rd_adapter_if.slave    bus
);

  // One buffer slot per read that can be in flight, plus one so a full
  // pipe of reads can still land while the head word is stalled.
  localparam int DEPTH = rd_latency + 1;
  localparam int CNT_W = cnt_w(DEPTH);

  generate
    if (rd_latency < 1 || rd_latency > MAX_RD_LATENCY) begin : g_bad_latency
      $error("dspba_fifo_rd_adapter: rd_latency out of range");
    end
  endgenerate

  logic [rd_latency-1:0] v_reg;
  logic [rd_latency-1:0] v_next;
  logic                  arrive;
  logic                  pop;
  logic [CNT_W-1:0]      inflight;
  logic [CNT_W-1:0]      count;
  logic [CNT_W:0]        credit_sum;
  logic [width-1:0]      head_data;

  // Valid shift pipe: bit i set means a read issued i+1 cycles ago.
  always_comb begin
    v_next = (v_reg << 1) | rd_latency'(bus.fifo_rdreq);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      v_reg <= '0;
    else
      v_reg <= v_next;
  end

  assign arrive = v_reg[rd_latency-1];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < rd_latency; i++)
      inflight = inflight + CNT_W'(v_reg[i]);
  end

  assign pop = bus.out_valid && bus.out_ready;

  // Words committed = buffered + in flight. A pop this cycle frees a slot
  // immediately, so reads resume in the same cycle out_ready rises.
  // pop implies count >= 1, so the subtraction cannot underflow.
  always_comb begin
    credit_sum = {1'b0, count} + {1'b0, inflight} - {{CNT_W{1'b0}}, pop};
  end

  assign bus.fifo_rdreq = reset && !bus.fifo_empty &&
                          (credit_sum < (CNT_W + 1)'(DEPTH));

  dspba_fifo_rd_buffer #(
    .width (width),
    .depth (DEPTH)
  ) u_buffer (
    .clk       (clk),
    .reset     (reset),
    .push      (arrive),
    .push_data (bus.fifo_q),
    .pop       (pop),
    .count     (count),
    .head_data (head_data)
  );

  assign bus.out_valid = (count != '0);
  assign bus.out_data  = head_data;

endmodule

// File: tb/tb_dspba_fifo_rd_adapter.sv
// tb_dspba_fifo_rd_adapter
// Eight adapter instances (rd_latency 1..4, width 8 and 37) share clk and
// reset. A queue model per instance tracks every word requested and not yet
// consumed, plus the cycle it becomes visible; the same model plays the
// source FIFO and drives fifo_q rd_latency cycles after each read.
module tb_dspba_fifo_rd_adapter;

  localparam int N = 8;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0] empty_v;
  logic [N-1:0] ready_v;
  logic [N-1:0] rdreq_v;
  logic [N-1:0] valid_v;
  logic [63:0]  fifo_q_a   [N];
  logic [63:0]  out_data_a [N];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  logic [63:0] src_base [N];
  int          src_idx  [N];
  ent_t        exp_q    [N][$];   // requested, not yet consumed
  ent_t        del_q    [N][$];   // source FIFO returns still to be driven

  function automatic int lat_of(input int i);
    return (i % 4) + 1;
  endfunction

  function automatic logic [63:0] mask_of(input int i);
    return (i < 4) ? 64'hFF : 64'h1F_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] src_word(input int i, input int k);
    logic [63:0] step;
    step = (i < 4) ? 64'd1 : 64'h0000_0001_0100_0001;
    return (src_base[i] + 64'(k) * step) & mask_of(i);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_dut
      localparam int W = (gi < 4) ? 8 : 37;
      localparam int L = (gi % 4) + 1;
      dspba_fifo_rd_adapter_if #(.width(W)) bus ();
      assign bus.fifo_empty = empty_v[gi];
      assign bus.out_ready  = ready_v[gi];
      assign bus.fifo_q     = fifo_q_a[gi][W-1:0];
      assign rdreq_v[gi]    = bus.fifo_rdreq;
      assign valid_v[gi]    = bus.out_valid;
      assign out_data_a[gi] = 64'(bus.out_data);
      dspba_fifo_rd_adapter #(.width(W), .rd_latency(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
      );
    end
  endgenerate

  task automatic check(input string name, input int inst,
                       input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req)
      pass_cnt++;
    else
      $display("FAIL %s inst%0d cyc%0d: got %0h required %0h",
               name, inst, cyc, act, req);
  endtask

  // Per-cycle compare and model advance, run mid-cycle.
  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      bit exp_valid;
      bit exp_pop;
      bit exp_rd;
      int outstanding;
      ent_t e;
      outstanding = exp_q[i].size();
      exp_valid = reset && (outstanding > 0) && (exp_q[i][0].cyc <= cyc);
      exp_pop   = exp_valid && ready_v[i];
      exp_rd    = reset && !empty_v[i] &&
                  ((outstanding - int'(exp_pop)) < (lat_of(i) + 1));
      check("rdreq", i, 64'(rdreq_v[i]), 64'(exp_rd));
      check("out_valid", i, 64'(valid_v[i]), 64'(exp_valid));
      if (exp_valid)
        check("out_data", i, out_data_a[i], exp_q[i][0].data);
      if (!reset) begin
        check("reset_data", i, out_data_a[i], 64'd0);
        exp_q[i].delete();
      end
      if (exp_pop)
        void'(exp_q[i].pop_front());
      if (exp_rd) begin
        e.data = src_word(i, src_idx[i]);
        e.cyc  = cyc + lat_of(i) + 1;
        exp_q[i].push_back(e);
        e.cyc  = cyc + lat_of(i);
        del_q[i].push_back(e);
        src_idx[i]++;
      end
      if (del_q[i].size() > 0 && del_q[i][0].cyc == cyc) begin
        e = del_q[i].pop_front();
        fifo_q_a[i] = e.data;
      end else begin
        fifo_q_a[i] = {$urandom(), $urandom()} & mask_of(i);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    empty_v = '1;
    ready_v = '1;
    repeat (n) tick();
  endtask

  task automatic set_src(input int i, input logic [63:0] base);
    src_base[i] = base;
    src_idx[i]  = 0;
  endtask

  initial begin
    int rd_win, rd_late, out_n, first_k, data_ok, rd_cnt, found;
    empty_v = '1;
    ready_v = '1;
    for (int i = 0; i < N; i++) begin
      fifo_q_a[i] = '0;
      set_src(i, 64'd0);
    end
    #1 reset = 1'b0;
    #1;
    check("rst_valid", 0, 64'(valid_v[0]), 64'd0);
    check("rst_rdreq", 5, 64'(rdreq_v[5]), 64'd0);
    check("rst_data", 7, out_data_a[7], 64'd0);
    repeat (2) tick();
    reset = 1'b1;
    idle(4);

    // Single word, rd_latency 2
    set_src(1, 64'hA5);
    ready_v[1] = 1'b0;
    empty_v[1] = 1'b0;
    #1 check("A_rdreq_t", 1, 64'(rdreq_v[1]), 64'd1);
    tick();
    empty_v[1] = 1'b1;
    #1 check("A_rdreq_t1", 1, 64'(rdreq_v[1]), 64'd0);
    tick();
    #1 check("A_valid_t2", 1, 64'(valid_v[1]), 64'd0);
    tick();
    #1 check("A_valid_t3", 1, 64'(valid_v[1]), 64'd1);
    check("A_data_t3", 1, out_data_a[1], 64'hA5);
    repeat (2) tick();
    #1 check("A_hold_valid", 1, 64'(valid_v[1]), 64'd1);
    check("A_hold_data", 1, out_data_a[1], 64'hA5);
    ready_v[1] = 1'b1;
    tick();
    #1 check("A_after_pop", 1, 64'(valid_v[1]), 64'd0);
    idle(8);

    // Burst of 16, rd_latency 3, out_ready held high
    set_src(2, 64'd0);
    rd_win = 0; rd_late = 0; out_n = 0; first_k = -1; data_ok = 1;
    for (int k = 0; k < 30; k++) begin
      empty_v[2] = (k >= 16);
      #1;
      if (rdreq_v[2]) begin
        if (k < 16) rd_win++;
        else rd_late++;
      end
      if (valid_v[2]) begin
        if (out_n == 0) first_k = k;
        if (out_data_a[2] != 64'(out_n) || k != first_k + out_n) data_ok = 0;
        out_n++;
      end
      tick();
    end
    check("B_rdreq_run", 2, 64'(rd_win), 64'd16);
    check("B_rdreq_late", 2, 64'(rd_late), 64'd0);
    check("B_first_out", 2, 64'(first_k), 64'd4);
    check("B_out_count", 2, 64'(out_n), 64'd16);
    check("B_out_seq", 2, 64'(data_ok), 64'd1);
    idle(8);

    // Backpressure, rd_latency 2
    set_src(1, 64'h40);
    ready_v[1] = 1'b0;
    empty_v[1] = 1'b0;
    rd_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (rdreq_v[1]) rd_cnt++;
      tick();
    end
    #1 check("C_reads_issued", 1, 64'(rd_cnt), 64'd3);
    check("C_rdreq_stalled", 1, 64'(rdreq_v[1]), 64'd0);
    ready_v[1] = 1'b1;
    #1 check("C_rdreq_resume", 1, 64'(rdreq_v[1]), 64'd1);
    check("C_first_data", 1, out_data_a[1], 64'h40);
    repeat (6) tick();
    idle(10);

    // Toggled out_ready on every instance with a continuous stream
    for (int k = 0; k < 80; k++) begin
      empty_v = '0;
      ready_v = (k % 2 == 1) ? '1 : '0;
      tick();
    end
    idle(12);

    // Reset mid-flight, rd_latency 4: 3 buffered and 2 in flight
    set_src(3, 64'h10);
    ready_v[3] = 1'b0;
    empty_v[3] = 1'b0;
    repeat (7) tick();
    #1 check("E_pre_valid", 3, 64'(valid_v[3]), 64'd1);
    check("E_pre_rdreq", 3, 64'(rdreq_v[3]), 64'd0);
    reset = 1'b0;
    #1 check("E_rst_valid", 3, 64'(valid_v[3]), 64'd0);
    tick();
    reset = 1'b1;
    ready_v[3] = 1'b1;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      #1;
      if (valid_v[3]) begin
        found = 1;
        check("E_next_word", 3, out_data_a[3], 64'h15);
      end
      tick();
    end
    if (found == 0) check("E_timeout", 3, 64'd0, 64'd1);
    idle(15);

    // Random sweep across all latencies and widths
    for (int i = 0; i < N; i++) set_src(i, {$urandom(), $urandom()});
    for (int k = 0; k < 2100; k++) begin
      case (k / 700)
        0: begin
          empty_v = 8'($urandom()) & 8'($urandom());
          ready_v = 8'($urandom()) | 8'($urandom());
        end
        1: begin
          empty_v = 8'($urandom());
          ready_v = 8'($urandom());
        end
        default: begin
          empty_v = 8'($urandom()) | 8'($urandom());
          ready_v = 8'($urandom()) & 8'($urandom());
        end
      endcase
      tick();
    end
    idle(20);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
